serial_rx_8: RTL
================

// Module: serial_rx_8
// PURPOSE
//  Receive end of the serial byte link driven by the 8-bit parallel-load shift register.
//  Collects WIDTH serial bits, LSB first, qualified by Shift_En into a right-shifting register.
//  Presents the assembled word on Data_Out with a Valid/Ack handshake.
//  Sits between the serial link and the datapath consumer (multiplier operand load, register file write).
// PARAMETERS
//  WIDTH   8   bits per frame; bit counter is $clog2(WIDTH+1) bits wide
// PORTS
//  Clk        in   1      system clock, all state updates on rising edge
//  Reset      in   1      synchronous, active-high reset
//  Start      in   1      1-cycle pulse: begin a new frame
//  Shift_En   in   1      sample Shift_In this cycle (RECV only)
//  Shift_In   in   1      serial data, LSB of the word first
//  Ack        in   1      consumer accepts Data_Out (meaningful only while Valid=1)
//  Data_Out   out  WIDTH  assembled word, stable while Valid=1
//  Valid      out  1      word available
//  Busy       out  1      frame in progress (state RECV)
//  Bit_Count  out  4      bits received in the current frame (0..WIDTH-1)
//  Overrun    out  1      sticky: Start seen while Valid=1 and Ack=0
// BEHAVIOUR
//  Reset: state IDLE; shift reg, Data_Out, Bit_Count = 0; Valid, Busy, Overrun = 0. Reset wins over every other input.
//  FSM states: IDLE, RECV, HOLD.
//  IDLE: Start=1 -> RECV, Bit_Count<=0, shift reg<=0. Shift_En and Ack are ignored.
//  Start cycle: Shift_In is not sampled; the first bit is taken on a later cycle.
//  RECV, Busy=1: on Shift_En=1, sr <= {Shift_In, sr[WIDTH-1:1]} and Bit_Count++.
//  RECV, Shift_En=0: hold state; gaps of any length are legal.
//  RECV, sampled bit with Bit_Count==WIDTH-1:
//   - Data_Out <= {Shift_In, sr[WIDTH-1:1]}; Valid<=1; Bit_Count<=0; -> HOLD.
//   - Valid rises the cycle after the WIDTH-th sampled bit (latency 1).
//  RECV, Start=1: restart the frame (Bit_Count<=0, sr<=0); partial bits are discarded. Start has priority over Shift_En.
//  HOLD, Valid=1: Data_Out frozen; Shift_En ignored.
//  HOLD, Ack=1: Valid<=0 next cycle -> IDLE. Data_Out keeps its last value.
//  HOLD, Ack=1 and Start=1 same cycle: Valid<=0 and enter RECV directly (back-to-back frames).
//  HOLD, Start=1 with Ack=0: Start is ignored, Overrun<=1, stay HOLD.
//  Overrun: cleared only by Reset.
//  Ack outside HOLD: no effect.
//  Outputs are all registered; no combinational input->output path.
// STRUCTURE
//  Package serial_link_pkg:
//   - typedef enum logic [1:0] {IDLE, RECV, HOLD} rx_state_t
//   - localparam SER_WIDTH = 8 (shared with the transmit shift register)
//  Sub-module shift_reg_rx: WIDTH-bit right shifter with Shift_En and synchronous clear (serial in at MSB).
//  FSM, counter and handshake are implemented in serial_rx_8.
// TESTING
//  1. Reset; Start; bits 1,0,1,0,0,1,0,1 on 8 consecutive Shift_En cycles
//     -> Data_Out=8'hA5, Valid=1 one cycle after the 8th bit, Busy=0.
//  2. Same frame 8'h3C with Shift_En gaps of 0-3 cycles between bits
//     -> Data_Out=8'h3C; Bit_Count tracks 0..7 and returns to 0.
//  3. Start, 4 bits, Start again, 8 bits for 8'hF0
//     -> Data_Out=8'hF0; the first 4 bits have no effect.
//  4. Valid=1 with Ack held 0, then Start pulse
//     -> Overrun=1, Data_Out unchanged; Ack+Start together -> Valid=0, Busy=1 next cycle.
//  5. Reset asserted after 5 bits -> all outputs 0, state IDLE; a new frame 8'h81 receives correctly.
//  6. Loopback: transmit register loads 8'h96 and shifts 8 cycles into Shift_In with Shift_En=1
//     -> Data_Out=8'h96.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial byte link (transmit shifter and receiver).
// Holds the receiver state encoding and the common frame width.
package serial_link_pkg;

  localparam int SER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } rx_state_t;

endpackage : serial_link_pkg

// File: rtl/shift_reg_rx.sv
// Right-shifting receive register: serial data enters at the MSB, so after
// WIDTH shifts the first bit received sits in bit 0 (LSB-first framing).
module shift_reg_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  // Each bit takes its upper neighbour; the top bit takes the serial input.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi+1];
    end
  endgenerate
  assign q_next[WIDTH-1] = serial_in;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      q_reg <= '0;
    end else if (shift_en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule : shift_reg_rx

// File: rtl/serial_rx_8.sv
// Serial byte receiver: assembles LSB-first bits qualified by Shift_En and
// hands the word to the consumer through a Valid/Ack handshake.
module serial_rx_8
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic             Ack,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  output logic             Busy,
  output logic [CNT_W-1:0] Bit_Count,
  output logic             Overrun
);

  rx_state_t        state_reg;
  logic [WIDTH-1:0] sr;
  logic             sr_clr;
  logic             sr_shift;
  logic             last_bit;
  logic             unused_lsb;

  // Bit 0 is still the cleared value when the final bit arrives, so the
  // completed word is formed from the upper bits plus the incoming bit.
  assign unused_lsb = sr[0];
  assign last_bit   = (Bit_Count == CNT_W'(WIDTH - 1));

  always_comb begin
    sr_clr   = 1'b0;
    sr_shift = 1'b0;
    case (state_reg)
      IDLE: sr_clr = Start;
      RECV: begin
        sr_clr   = Start;
        sr_shift = Shift_En && !Start;
      end
      HOLD: sr_clr = Start && Ack;
      default: sr_clr = 1'b0;
    endcase
  end

  shift_reg_rx #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk      (Clk),
    .srst     (Reset),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .serial_in(Shift_In),
    .q        (sr)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      Data_Out  <= '0;
      Valid     <= 1'b0;
      Busy      <= 1'b0;
      Bit_Count <= '0;
      Overrun   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            state_reg <= RECV;
            Busy      <= 1'b1;
            Bit_Count <= '0;
          end
        end
        RECV: begin
          if (Start) begin
            Bit_Count <= '0;
          end else if (Shift_En) begin
            if (last_bit) begin
              Data_Out  <= {Shift_In, sr[WIDTH-1:1]};
              Valid     <= 1'b1;
              Busy      <= 1'b0;
              Bit_Count <= '0;
              state_reg <= HOLD;
            end else begin
              Bit_Count <= Bit_Count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (Ack) begin
            Valid <= 1'b0;
            if (Start) begin
              // Back-to-back frame: accept the word and start collecting at once.
              state_reg <= RECV;
              Busy      <= 1'b1;
              Bit_Count <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else if (Start) begin
            Overrun <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          Valid     <= 1'b0;
          Busy      <= 1'b0;
          Bit_Count <= '0;
        end
      endcase
    end
  end

endmodule : serial_rx_8
